// File: rtl/word_serializer_if.sv
// Parallel-load / serial-out handshake bundle for word_serializer.
// Both sides follow valid/ready: a transfer happens on an edge where valid and ready are both 1.
interface word_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] D;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output D, load_valid, sout_ready,
        input  load_ready, sout, sout_valid, done, dbg_state
    );

    modport slave (
        input  D, load_valid, sout_ready,
        output load_ready, sout, sout_valid, done, dbg_state
    );
endinterface

// File: rtl/word_serializer.sv
// Loads a WIDTH-bit word and shifts it out MSB first, one bit per consumed beat,
// then raises done for one cycle before accepting the next word.
module word_serializer #(
    parameter int WIDTH = 32
) (
    input logic              En,
    input logic              r,
    word_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge En or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode from the registered state, so reset clears them at once.
    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        cnt_d          = cnt_q;
        bus.load_ready = 1'b0;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    sreg_d  = bus.D;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.sout_valid = 1'b1;
                bus.sout       = sreg_q[WIDTH-1];
                if (bus.sout_ready) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_word_serializer.sv
// Directed and random stimulus for word_serializer, checked against a queue-of-bits model.
module tb_word_serializer;
    localparam int W = 32;

    logic En = 1'b0;
    logic r  = 1'b0;

    word_serializer_if #(.WIDTH(W)) bus ();
    word_serializer #(.WIDTH(W)) dut (.En(En), .r(r), .bus(bus));

    always #5 En = ~En;

    int checks = 0;
    int errors = 0;

    // Model: bits still owed for the word in flight, plus the pending done beat.
    logic         exp_bits[$];
    bit           exp_done = 0;
    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           load_cyc = -1;
    int           prev_load = -1;
    int           done_cyc = -1;
    bit           check_spacing = 0;
    logic [W-1:0] rx_word = '0;
    int           rx_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = exp_bits.size() > 0;
        chk("sout_valid", 32'(bus.sout_valid), 32'(v));
        chk("sout", 32'(bus.sout), v ? 32'(exp_bits[0]) : 32'd0);
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("load_ready", 32'(bus.load_ready), 32'(!v && !exp_done));
    endtask

    // Check the current cycle, advance the model across the next edge, then step the clock.
    task automatic cycle();
        bit v;
        v = exp_bits.size() > 0;
        check_outputs();
        if (bus.sout_valid && bus.sout_ready) begin
            rx_word = {rx_word[W-2:0], bus.sout};
            rx_cnt++;
        end
        if (bus.done) begin
            done_cyc = cyc;
            chk("word_bit_count", 32'(rx_cnt), 32'(W));
            chk("word_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk("word_data", rx_word, exp_q.pop_front());
            rx_cnt  = 0;
            rx_word = '0;
        end
        if (v && bus.sout_ready) begin
            void'(exp_bits.pop_front());
            if (exp_bits.size() == 0) exp_done = 1;
        end else if (exp_done) begin
            exp_done = 0;
        end else if (!v && bus.load_valid) begin
            for (int i = W - 1; i >= 0; i--) exp_bits.push_back(bus.D[i]);
            exp_q.push_back(bus.D);
            if (check_spacing && prev_load >= 0) chk("load_spacing", 32'(cyc - prev_load), 32'(W + 2));
            prev_load = cyc;
            load_cyc  = cyc;
        end
        @(posedge En);
        #1;
        cyc++;
    endtask

    task automatic load_word(input logic [W-1:0] d);
        bus.D          = d;
        bus.load_valid = 1'b1;
        cycle();
        bus.load_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_bits.size() > 0 || exp_done) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_load;
        bus.D          = '0;
        bus.load_valid = 1'b0;
        bus.sout_ready = 1'b0;

        // Reset held for three edges, outputs must sit idle.
        repeat (3) begin
            @(posedge En);
            #1;
            check_outputs();
        end
        chk("reset_load_ready", 32'(bus.load_ready), 32'd1);
        #2 r = 1'b1;

        // Basic word.
        bus.sout_ready = 1'b1;
        load_word(32'hA500_0001);
        drain(100);
        chk("basic_done_latency", 32'(done_cyc - load_cyc), 32'(W + 1));
        cycle();

        // Backpressure on the first bit for five cycles.
        bus.sout_ready = 1'b0;
        load_word(32'h8000_0000);
        repeat (5) cycle();
        bus.sout_ready = 1'b1;
        drain(100);
        chk("stall_done_latency", 32'(done_cyc - load_cyc), 32'(W + 6));
        cycle();

        // Load requests while busy are ignored until the cycle after done.
        load_word(32'h0000_0000);
        bus.D          = 32'hFFFF_FFFF;
        bus.load_valid = 1'b1;
        drain(100);
        stall_load = done_cyc;
        cycle();
        bus.load_valid = 1'b0;
        chk("busy_load_after_done", 32'(load_cyc - stall_load), 32'd1);
        chk("busy_word_after_zero", exp_q[0], 32'hFFFF_FFFF);
        drain(100);
        cycle();

        // Reset in the middle of a word: immediate idle, no done, clean restart.
        load_word(32'h1234_5678);
        repeat (11) cycle();
        #2 r = 1'b0;
        #1;
        exp_bits.delete();
        exp_done = 0;
        exp_q.delete();
        rx_cnt  = 0;
        rx_word = '0;
        chk("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sout", 32'(bus.sout), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'd0);
        @(posedge En);
        #1;
        cyc++;
        check_outputs();
        #2 r = 1'b1;
        stall_load = cyc;
        load_word(32'($urandom()));
        chk("first_edge_load", 32'(load_cyc), 32'(stall_load));
        drain(100);
        cycle();

        // Back-to-back loads with D churning every cycle.
        check_spacing  = 1;
        prev_load      = -1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 4 * (W + 2); i++) begin
            bus.D = 32'($urandom());
            cycle();
        end
        bus.load_valid = 1'b0;
        check_spacing  = 0;
        drain(100);
        cycle();

        // Random backpressure and random load requests.
        for (int i = 0; i < 400; i++) begin
            bus.D          = 32'($urandom());
            bus.load_valid = ($urandom_range(0, 3) == 0);
            bus.sout_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.load_valid = 1'b0;
        bus.sout_ready = 1'b1;
        drain(200);
        cycle();
        chk("all_words_seen", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
